spi_cmd_log_iomem: RTL and testbench

Parametrised iomem peripheral that timestamps and queues every decoded SPI flash command (cmd, addr, len) reported by the `uspispy` logical interface, so firmware no longer loses commands that arrive faster than it can poll a single capture register. Sits on the picosoc iomem bus beside the gpio and spi controller peripherals, in the `clk` domain. Adds a DEPTH-entry FIFO, command match/mask filtering, drop accounting and a threshold interrupt.

---
 rtl/spi_log_pkg.sv | 39 +++
 rtl/log_fifo.sv | 53 +++++
 rtl/spi_cmd_log_iomem.sv | 158 +++++++++++++++
 tb/tb_spi_cmd_log_iomem.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_log_pkg.sv
// Shared definitions for the SPI command log: register map, entry layout, filler value.
// An entry is packed as {ts, spi_log_cmd_t}, i.e. {ts, cmd, addr, len}: TS_WIDTH+52 bits.
package spi_log_pkg;

   localparam logic [7:0] REG_STATUS = 8'h00;
   localparam logic [7:0] REG_HEAD0  = 8'h04;
   localparam logic [7:0] REG_HEAD1  = 8'h08;
   localparam logic [7:0] REG_HEAD2  = 8'h0C;
   localparam logic [7:0] REG_POP    = 8'h10;
   localparam logic [7:0] REG_CTRL   = 8'h14;
   localparam logic [7:0] REG_FILTER = 8'h18;
   localparam logic [7:0] REG_DROPS  = 8'h1C;
   localparam logic [7:0] REG_TIME   = 8'h20;

   localparam int CMD_W        = 8;
   localparam int ADDR_W       = 32;
   localparam int LEN_W        = 12;
   localparam int CMD_FIELDS_W = CMD_W + ADDR_W + LEN_W;

   localparam logic [31:0] FILLER    = 32'hDECAFBAD;
   localparam logic [15:0] DROPS_MAX = 16'hFFFF;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } spi_log_cmd_t;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++)
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      return res;
   endfunction

endpackage

// File: rtl/log_fifo.sv
// Single-clock FIFO with pointer + count bookkeeping and a combinational head read.
// A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
module log_fifo #(
   parameter int WIDTH = 76,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count define validity, and a reset here would block RAM inference.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/spi_cmd_log_iomem.sv
// iomem peripheral that timestamps, filters and queues decoded SPI flash commands.
// Holds the timestamp, filter, register file, drop accounting and threshold interrupt.
module spi_cmd_log_iomem
   import spi_log_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int TS_WIDTH = 24,
   parameter int TICK_DIV = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_strobe,
   input  logic [7:0]  cmd,
   input  logic [31:0] addr,
   input  logic [11:0] len,
   input  logic        sel,
   input  logic [7:0]  bus_addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = TS_WIDTH + CMD_FIELDS_W;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0]       presc;
   logic [TS_WIDTH-1:0] ts;

   logic                enable;
   logic                irq_en;
   logic [8:0]          irq_thresh;
   logic [7:0]          filter_mask;
   logic [7:0]          filter_match;
   logic [15:0]         drops;
   logic                overflow;

   logic                acc, rd, wr;
   logic                pop_req, accept, drop, drops_clr, ovf_clr;
   logic [31:0]         ctrl_word, ctrl_new, filter_word, filter_new;
   logic [31:0]         rd_mux;

   logic [EW-1:0]       fifo_din, fifo_dout;
   logic                fifo_full, fifo_empty;
   logic [AW:0]         fifo_count;
   logic [8:0]          count9;
   spi_log_cmd_t        new_cmd, head_cmd;
   logic [31:0]         head_ts;

   // Timestamp advances once per TICK_DIV clocks.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         ts    <= '0;
      end else if (presc == PW'(TICK_DIV - 1)) begin
         presc <= '0;
         ts    <= ts + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // A bus access is acted on only in the cycle that raises ready.
   assign acc       = sel && !ready;
   assign wr        = acc && (wstrb != 4'b0);
   assign rd        = acc && (wstrb == 4'b0);
   assign pop_req   = wr && (bus_addr == REG_POP);
   assign drops_clr = wr && (bus_addr == REG_DROPS);
   assign ovf_clr   = wr && (bus_addr == REG_STATUS) && wstrb[0] && wdata[2];

   assign accept = cmd_strobe && enable && (((cmd ^ filter_match) & filter_mask) == 8'h00);
   assign drop   = accept && fifo_full && !pop_req;

   assign new_cmd  = '{cmd: cmd, addr: addr, len: len};
   assign fifo_din = {ts, new_cmd};

   log_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (pop_req),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_cmd = fifo_dout[CMD_FIELDS_W-1:0];
   assign head_ts  = 32'(fifo_dout[EW-1 -: TS_WIDTH]);
   assign count9   = 9'(fifo_count);

   assign ctrl_word   = {15'b0, irq_thresh, 6'b0, irq_en, enable};
   assign filter_word = {16'b0, filter_mask, filter_match};
   assign ctrl_new    = apply_wstrb(ctrl_word, wdata, wstrb);
   assign filter_new  = apply_wstrb(filter_word, wdata, wstrb);

   // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
   always_comb begin
      rd_mux = FILLER;
      case (bus_addr)
         REG_STATUS: rd_mux = {15'b0, count9, 5'b0, overflow, fifo_full, fifo_empty};
         REG_HEAD0:  rd_mux = fifo_empty ? 32'h0 : {head_ts[23:0], head_cmd.cmd};
         REG_HEAD1:  rd_mux = fifo_empty ? 32'h0 : head_cmd.addr;
         REG_HEAD2:  rd_mux = fifo_empty ? 32'h0 : {head_ts[31:24], 12'b0, head_cmd.len};
         REG_POP:    rd_mux = 32'h0;
         REG_CTRL:   rd_mux = ctrl_word;
         REG_FILTER: rd_mux = filter_word;
         REG_DROPS:  rd_mux = {16'b0, drops};
         REG_TIME:   rd_mux = 32'(ts);
         default:    rd_mux = FILLER;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready        <= 1'b0;
         rdata        <= '0;
         irq          <= 1'b0;
         enable       <= 1'b0;
         irq_en       <= 1'b0;
         irq_thresh   <= '0;
         filter_mask  <= '0;
         filter_match <= '0;
         drops        <= '0;
         overflow     <= 1'b0;
      end else begin
         ready <= acc;
         rdata <= rd ? rd_mux : 32'h0;
         irq   <= irq_en && (irq_thresh != 9'd0) && (count9 >= irq_thresh);

         if (wr && bus_addr == REG_CTRL) begin
            enable     <= ctrl_new[0];
            irq_en     <= ctrl_new[1];
            irq_thresh <= ctrl_new[16:8];
         end
         if (wr && bus_addr == REG_FILTER) begin
            filter_match <= filter_new[7:0];
            filter_mask  <= filter_new[15:8];
         end

         // A clear wins over a simultaneous drop; a drop wins over a W1C.
         if (drops_clr)
            drops <= '0;
         else if (drop && drops != DROPS_MAX)
            drops <= drops + 1'b1;

         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_cmd_log_iomem.sv
// Self-checking bench for spi_cmd_log_iomem: random commands against a queue-based model.
module tb_spi_cmd_log_iomem;

   localparam int DEPTH    = 16;
   localparam int TS_WIDTH = 24;
   localparam int TICK_DIV = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_strobe = 1'b0;
   logic [7:0]  cmd = '0;
   logic [31:0] addr = '0;
   logic [11:0] len = '0;
   logic        sel = 1'b0;
   logic [7:0]  bus_addr = '0;
   logic [3:0]  wstrb = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic        irq;

   spi_cmd_log_iomem #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .TICK_DIV(TICK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_strobe (cmd_strobe),
      .cmd        (cmd),
      .addr       (addr),
      .len        (len),
      .sel        (sel),
      .bus_addr   (bus_addr),
      .wstrb      (wstrb),
      .wdata      (wdata),
      .rdata      (rdata),
      .ready      (ready),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Clock edges since reset was released; the timestamp is this divided by TICK_DIV.
   int unsigned mc;
   always @(posedge clk) begin
      if (reset) mc <= 0;
      else       mc <= mc + 1;
   end

   typedef struct {
      logic [31:0] ts;
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [11:0] len;
   } ent_t;

   ent_t        q[$];
   bit          m_en, m_irq_en, m_ovf, m_irq;
   int          m_thresh;
   logic [7:0]  m_mask, m_match;
   int          m_drops;

   int passed = 0;
   int total  = 0;

   function automatic logic [31:0] cur_ts();
      longint t;
      t = longint'(mc / TICK_DIV) % (64'd1 << TS_WIDTH);
      return 32'(t);
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      bit e;
      e = (q.size() == 0);
      case (a)
         8'h00: return {15'd0, 9'(q.size()), 5'd0, m_ovf, q.size() == DEPTH, e};
         8'h04: return e ? 32'h0 : {q[0].ts[23:0], q[0].cmd};
         8'h08: return e ? 32'h0 : q[0].addr;
         8'h0C: return e ? 32'h0 : {q[0].ts[31:24], 12'd0, q[0].len};
         8'h10: return 32'h0;
         8'h14: return {15'd0, 9'(m_thresh), 6'd0, m_irq_en, m_en};
         8'h18: return {16'd0, m_mask, m_match};
         8'h1C: return {16'd0, 16'(m_drops)};
         8'h20: return cur_ts();
         default: return 32'hDECAFBAD;
      endcase
   endfunction

   function automatic void model_clear();
      q.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_irq = 0;
      m_thresh = 0; m_mask = 0; m_match = 0; m_drops = 0;
   endfunction

   // Applies one clock edge worth of behaviour, using the state before that edge.
   function automatic void model_edge(input bit do_sel, input logic [7:0] a, input logic [3:0] s,
                                      input logic [31:0] d, input bit stb, input logic [7:0] c,
                                      input logic [31:0] ad, input logic [11:0] ln);
      bit nirq, w, drop;
      logic [31:0] v;
      nirq = m_irq_en && m_thresh != 0 && q.size() >= m_thresh;
      w    = do_sel && s != 4'b0;
      drop = 0;
      if (w && a == 8'h10 && q.size() > 0) void'(q.pop_front());
      if (stb && m_en && ((c ^ m_match) & m_mask) == 8'h00) begin
         if (q.size() < DEPTH) q.push_back('{cur_ts(), c, ad, ln});
         else drop = 1;
      end
      if (w && (a == 8'h14 || a == 8'h18)) begin
         v = model_read(a);
         for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
         if (a == 8'h14) begin
            m_en = v[0]; m_irq_en = v[1]; m_thresh = int'(v[16:8]);
         end else begin
            m_match = v[7:0]; m_mask = v[15:8];
         end
      end
      if (w && a == 8'h1C) m_drops = 0;
      else if (drop && m_drops < 65535) m_drops++;
      if (drop) m_ovf = 1;
      else if (w && a == 8'h00 && s[0] && d[2]) m_ovf = 0;
      m_irq = nirq;
   endfunction

   task automatic tick();
      model_edge(0, 8'h0, 4'h0, 32'h0, 0, 8'h0, 32'h0, 12'h0);
      @(posedge clk);
      #1;
   endtask

   // One edge with optional bus access and/or strobe; bus accesses get an idle cycle after.
   task automatic op(input bit do_sel, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                     input bit stb, input logic [7:0] c, input logic [31:0] ad, input logic [11:0] ln,
                     output logic [31:0] r, output logic rdy, output logic [31:0] e);
      e = (do_sel && s == 4'b0) ? model_read(a) : 32'h0;
      model_edge(do_sel, a, s, d, stb, c, ad, ln);
      sel = do_sel; bus_addr = a; wstrb = s; wdata = d;
      cmd_strobe = stb; cmd = c; addr = ad; len = ln;
      @(posedge clk);
      #1;
      r = rdata; rdy = ready;
      sel = 1'b0; wstrb = 4'b0; cmd_strobe = 1'b0;
      if (do_sel) tick();
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] r, output logic rdy, output logic [31:0] e);
      op(1, a, 4'h0, 32'h0, 0, 8'h0, 32'h0, 12'h0, r, rdy, e);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] r, e;
      logic rdy;
      op(1, a, 4'hF, d, 0, 8'h0, 32'h0, 12'h0, r, rdy, e);
   endtask

   task automatic strobe(input logic [7:0] c, input logic [31:0] ad, input logic [11:0] ln);
      logic [31:0] r, e;
      logic rdy;
      op(0, 8'h0, 4'h0, 32'h0, 1, c, ad, ln, r, rdy, e);
   endtask

   task automatic apply_reset();
      sel = 1'b0; cmd_strobe = 1'b0; wstrb = 4'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   // Reads a register and compares it (and ready) against the model.
   task automatic rd_check(input logic [7:0] a, input string name);
      logic [31:0] r, e;
      logic rdy;
      rd(a, r, rdy, e);
      total++;
      if ({rdy, r} !== {1'b1, e})
         $display("FAIL %s: ready=%b rdata=%h, expected ready=1 rdata=%h", name, rdy, r, e);
      else passed++;
   endtask

   task automatic test_reset();
      logic [31:0] r, e;
      logic rdy;
      apply_reset();
      total++;
      if ({ready, irq, rdata} !== {1'b0, 1'b0, 32'h0})
         $display("FAIL reset_outputs: ready=%b irq=%b rdata=%h, expected 0 0 0", ready, irq, rdata);
      else passed++;
      repeat (160) tick();
      rd(8'h20, r, rdy, e);
      total++;
      if ({rdy, r} !== {1'b1, 32'd10})
         $display("FAIL time_160: ready=%b rdata=%h, expected ready=1 rdata=0000000a", rdy, r);
      else passed++;
      rd(8'h00, r, rdy, e);
      total++;
      if ({rdy, r} !== {1'b1, 32'h1})
         $display("FAIL status_reset: ready=%b rdata=%h, expected 00000001", rdy, r);
      else passed++;
      rd_check(8'h24, "unmapped_read");
      rd_check(8'h10, "pop_read");
      rd_check(8'h20, "time_model");
   endtask

   task automatic test_single();
      logic [31:0] r, e;
      logic rdy;
      apply_reset();
      wr(8'h14, 32'h1);
      strobe(8'h03, 32'h0012_3456, 12'h100);
      rd(8'h00, r, rdy, e);
      total++;
      if (r[16:8] !== 9'd1) $display("FAIL single_count: count=%0d, expected 1", r[16:8]);
      else passed++;
      rd(8'h08, r, rdy, e);
      total++;
      if (r !== 32'h0012_3456) $display("FAIL single_head1: got %h, expected 00123456", r);
      else passed++;
      rd(8'h0C, r, rdy, e);
      total++;
      if (r[11:0] !== 12'h100) $display("FAIL single_head2: len=%h, expected 100", r[11:0]);
      else passed++;
      rd_check(8'h04, "single_head0");
      wr(8'h10, 32'h0);
      rd(8'h00, r, rdy, e);
      total++;
      if (r !== 32'h1) $display("FAIL single_pop_empty: status=%h, expected 00000001", r);
      else passed++;
      rd_check(8'h08, "single_head1_empty");
   endtask

   task automatic drain(input string name);
      while (q.size() > 0) begin
         rd_check(8'h04, {name, "_head0"});
         rd_check(8'h08, {name, "_head1"});
         rd_check(8'h0C, {name, "_head2"});
         wr(8'h10, $urandom);
      end
      rd_check(8'h00, {name, "_drained"});
   endtask

   task automatic test_overflow();
      logic [31:0] r, e, first_addr;
      logic rdy;
      apply_reset();
      wr(8'h14, 32'h1);
      first_addr = $urandom;
      strobe(8'($urandom), first_addr, 12'($urandom));
      for (int i = 1; i < DEPTH + 2; i++) begin
         strobe(8'($urandom), $urandom, 12'($urandom));
         if ($urandom_range(0, 2) == 0) tick();
      end
      rd(8'h00, r, rdy, e);
      total++;
      if (r !== 32'h0000_1006) $display("FAIL ovf_status: got %h, expected 00001006", r);
      else passed++;
      rd(8'h1C, r, rdy, e);
      total++;
      if (r !== 32'd2) $display("FAIL ovf_drops: got %0d, expected 2", r);
      else passed++;
      rd(8'h08, r, rdy, e);
      total++;
      if (r !== first_addr) $display("FAIL ovf_head_first: got %h, expected %h", r, first_addr);
      else passed++;
      wr(8'h00, 32'h4);
      rd(8'h00, r, rdy, e);
      total++;
      if (r !== 32'h0000_1002) $display("FAIL ovf_w1c: got %h, expected 00001002", r);
      else passed++;
      drain("ovf");
   endtask

   task automatic test_filter();
      logic [31:0] r, e;
      logic rdy;
      logic [7:0] c;
      apply_reset();
      wr(8'h14, 32'h1);
      wr(8'h18, 32'hFF02);
      strobe(8'h02, $urandom, 12'($urandom));
      strobe(8'h03, $urandom, 12'($urandom));
      strobe(8'h02, $urandom, 12'($urandom));
      rd(8'h00, r, rdy, e);
      total++;
      if (r !== 32'h0000_0200) $display("FAIL filter_count: status=%h, expected 00000200", r);
      else passed++;
      for (int i = 0; i < 2; i++) begin
         rd(8'h04, r, rdy, e);
         total++;
         if (r[7:0] !== 8'h02) $display("FAIL filter_cmd%0d: cmd=%h, expected 02", i, r[7:0]);
         else passed++;
         wr(8'h10, 32'h0);
      end
      for (int round = 0; round < 3; round++) begin
         wr(8'h18, {16'h0, 8'($urandom), 8'($urandom)});
         for (int i = 0; i < 20; i++) begin
            c = 8'($urandom);
            if ($urandom_range(0, 1) == 1) c = m_match ^ (c & ~m_mask);
            strobe(c, $urandom, 12'($urandom));
         end
         rd_check(8'h00, "filter_rand_status");
         rd_check(8'h1C, "filter_rand_drops");
         drain("filter_rand");
      end
      wr(8'h14, 32'h0);
      strobe(8'h02, $urandom, 12'($urandom));
      rd_check(8'h00, "disabled_status");
      rd_check(8'h1C, "disabled_drops");
   endtask

   task automatic test_back_to_back();
      logic [31:0] r, e;
      logic rdy;
      apply_reset();
      wr(8'h14, 32'h1);
      for (int i = 0; i < DEPTH; i++) strobe(8'($urandom), $urandom, 12'($urandom));
      op(1, 8'h10, 4'hF, 32'h0, 1, 8'hA5, 32'hCAFE_0001, 12'h7FF, r, rdy, e);
      rd(8'h00, r, rdy, e);
      total++;
      if (r !== 32'h0000_1002) $display("FAIL b2b_full_pop_push: status=%h, expected 00001002", r);
      else passed++;
      rd(8'h1C, r, rdy, e);
      total++;
      if (r !== 32'h0) $display("FAIL b2b_drops: got %0d, expected 0", r);
      else passed++;
      strobe(8'($urandom), $urandom, 12'($urandom));
      op(1, 8'h00, 4'hF, 32'h4, 1, 8'($urandom), $urandom, 12'($urandom), r, rdy, e);
      rd(8'h00, r, rdy, e);
      total++;
      if (r[2] !== 1'b1) $display("FAIL w1c_vs_drop: overflow=%b, expected 1", r[2]);
      else passed++;
      op(1, 8'h1C, 4'hF, 32'h0, 1, 8'($urandom), $urandom, 12'($urandom), r, rdy, e);
      rd(8'h1C, r, rdy, e);
      total++;
      if (r !== 32'h0) $display("FAIL drops_clr_vs_drop: got %0d, expected 0", r);
      else passed++;
      drain("b2b");
      op(1, 8'h10, 4'hF, 32'h0, 1, 8'h5A, 32'h1234_5678, 12'h00F, r, rdy, e);
      rd(8'h00, r, rdy, e);
      total++;
      if (r[16:8] !== 9'd1) $display("FAIL empty_pop_push: count=%0d, expected 1", r[16:8]);
      else passed++;
      drain("b2b_empty");
   endtask

   task automatic test_irq();
      apply_reset();
      wr(8'h14, 32'h0000_0303);
      for (int i = 0; i < 3; i++) strobe(8'($urandom), $urandom, 12'($urandom));
      total++;
      if ({irq, m_irq} !== 2'b00) $display("FAIL irq_lag: irq=%b model=%b, expected 0", irq, m_irq);
      else passed++;
      tick();
      total++;
      if (irq !== 1'b1) $display("FAIL irq_rise: irq=%b, expected 1", irq);
      else passed++;
      wr(8'h10, 32'h0);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_fall: irq=%b, expected 0", irq);
      else passed++;
      rd_check(8'h14, "irq_ctrl");
      // Reset lands while an access is being presented.
      bus_addr = 8'h14; wstrb = 4'h0; sel = 1'b1; reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         total++;
         if ({ready, irq} !== 2'b00) $display("FAIL reset_sel%0d: ready=%b irq=%b, expected 0 0", i, ready, irq);
         else passed++;
      end
      sel = 1'b0; reset = 1'b0;
      model_clear();
      rd_check(8'h00, "post_reset_status");
      rd_check(8'h14, "post_reset_ctrl");
      rd_check(8'h18, "post_reset_filter");
      rd_check(8'h1C, "post_reset_drops");
      rd_check(8'h20, "post_reset_time");
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single();
      test_overflow();
      test_filter();
      test_back_to_back();
      test_irq();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
